// File: rtl/io_input_ctrl.sv
// Four-port input front end: per-port strobe synchronizers with rising-edge capture,
// holding registers with valid/overrun flags, and a combinational selected-port read path.
module io_input_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [3:0]       stb,
    input  logic [1:0]       sel,
    input  logic             rd,
    output logic [WIDTH-1:0] dato_out,
    output logic [3:0]       valid,
    output logic [3:0]       overrun,
    output logic             irq
);

    logic [WIDTH-1:0] portData [4];
    logic [WIDTH-1:0] holdReg  [4];
    logic [3:0]       capture;
    logic [3:0]       rdHit;

    assign portData[0] = in_a;
    assign portData[1] = in_b;
    assign portData[2] = in_c;
    assign portData[3] = in_d;

    for (genvar p = 0; p < 4; p++) begin : gPort
        logic [SYNC_STAGES-1:0] syncChain;
        logic                   stbHistory;
        logic [WIDTH-1:0]       holdQ;
        logic                   validQ;
        logic                   overrunQ;

        assign capture[p] = syncChain[SYNC_STAGES-1] & ~stbHistory;
        assign rdHit[p]   = rd && (sel == 2'(p));

        // Capture beats a same-cycle read; the read still consumed the old value,
        // so overrun is cleared rather than set in that case.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                syncChain  <= '0;
                stbHistory <= 1'b0;
                holdQ      <= '0;
                validQ     <= 1'b0;
                overrunQ   <= 1'b0;
            end else begin
                syncChain  <= {syncChain[SYNC_STAGES-2:0], stb[p]};
                stbHistory <= syncChain[SYNC_STAGES-1];
                if (capture[p]) begin
                    holdQ  <= portData[p];
                    validQ <= 1'b1;
                    if (rdHit[p]) begin
                        overrunQ <= 1'b0;
                    end else if (validQ) begin
                        overrunQ <= 1'b1;
                    end
                end else if (rdHit[p]) begin
                    validQ   <= 1'b0;
                    overrunQ <= 1'b0;
                end
            end
        end

        assign holdReg[p] = holdQ;
        assign valid[p]   = validQ;
        assign overrun[p] = overrunQ;
    end

    assign dato_out = holdReg[sel];
    assign irq      = |valid;

endmodule
